// File: rtl/event_serializer_pkg.sv
// rtl/event_serializer_pkg.sv - shared neuromorphic event sizing helpers and event type
package event_serializer_pkg;

  localparam int DEF_NEURON_NUMBER = 256;
  localparam int DEF_TS_WIDTH      = 16;

  // Event word is {time stamp, neuron address}
  function automatic int event_width(input int neuron_number, input int ts_width);
    return ts_width + $clog2(neuron_number);
  endfunction

  // Whole bytes needed to carry one event on the byte link
  function automatic int event_bytes(input int ev_width);
    return (ev_width + 7) / 8;
  endfunction

  localparam int DEF_EVENT_WIDTH = event_width(DEF_NEURON_NUMBER, DEF_TS_WIDTH);
  localparam int DEF_EVENT_BYTES = event_bytes(DEF_EVENT_WIDTH);

  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0]               time_stamp;
    logic [$clog2(DEF_NEURON_NUMBER)-1:0]  neuron_addr;
  } event_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, full and empty flags
module sync_fifo #(
  parameter  int WIDTH   = 24,
  parameter  int DEPTH   = 16,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == LEVEL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/event_serializer.sv
// rtl/event_serializer.sv - buffers spike events and streams them MSB-first as bytes
module event_serializer
  import event_serializer_pkg::*;
#(
  parameter  int NEURON_NUMBER = 256,
  parameter  int TS_WIDTH      = 16,
  parameter  int FIFO_DEPTH    = 16,
  localparam int EVENT_WIDTH   = event_width(NEURON_NUMBER, TS_WIDTH),
  localparam int EVENT_BYTES   = event_bytes(EVENT_WIDTH),
  localparam int LEVEL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spike_in,
  input  logic [EVENT_WIDTH-1:0] event_in,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  input  logic                   clear_overflow,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [LEVEL_W-1:0]     fifo_level
);

  localparam int SHIFT_W = EVENT_BYTES * 8;
  localparam int IDX_W   = (EVENT_BYTES > 1) ? $clog2(EVENT_BYTES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]             state_q, state_d;
  logic                   valid_q, valid_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_q, drop_d;

  logic                   fifo_full, fifo_empty;
  logic [EVENT_WIDTH-1:0] fifo_dout;
  logic                   hs, last_byte, pop, push, drop;

  // A full FIFO still accepts a spike when the serializer frees a slot that same cycle
  always_comb begin
    hs        = valid_q & byte_ready;
    last_byte = (idx_q == IDX_W'(EVENT_BYTES - 1));
    pop       = ~fifo_empty & ((state_q == S_IDLE) | (hs & last_byte));
    push      = spike_in & (~fifo_full | pop);
    drop      = spike_in & ~push;
  end

  sync_fifo #(
    .WIDTH (EVENT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (event_in),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Serializer FSM: load an event, shift out a byte per handshake, chain events without a bubble
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = SHIFT_W'(fifo_dout);
          idx_d   = '0;
          state_d = S_SEND;
          valid_d = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          if (last_byte) begin
            if (pop) begin
              shift_d = SHIFT_W'(fifo_dout);
              idx_d   = '0;
            end else begin
              shift_d = shift_q << 8;
              state_d = S_IDLE;
              valid_d = 1'b0;
            end
          end else begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Drop accounting: a drop in the same cycle as a clear restarts the count at one
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow)      drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign byte_out   = shift_q[SHIFT_W-1 -: 8];
  assign byte_valid = valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_event_serializer.sv
// tb/tb_event_serializer.sv - randomized self-checking bench with transaction-level model
module tb_event_serializer;

  localparam int DEPTH = 16;
  localparam int EB    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spike_in = 1'b0;
  logic [23:0] event_in = '0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [4:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of buffered events, queue of bytes still owed for the event in flight
  logic [23:0] m_fifo[$];
  logic [7:0]  m_out[$];
  bit          m_ovf = 0;
  int          m_drops = 0;

  event_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .spike_in       (spike_in),
    .event_in       (event_in),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit hs, last, pop, push;
    logic [23:0] e;
    if (reset) begin
      m_fifo.delete(); m_out.delete(); m_ovf = 0; m_drops = 0;
    end else begin
      hs   = (m_out.size() > 0) && byte_ready;
      last = hs && (m_out.size() == 1);
      pop  = (m_fifo.size() > 0) && ((m_out.size() == 0) || last);
      push = spike_in && ((m_fifo.size() < DEPTH) || pop);
      if (hs) void'(m_out.pop_front());
      if (pop) begin
        e = m_fifo.pop_front();
        for (int b = 0; b < EB; b++) m_out.push_back(e[23-8*b -: 8]);
      end
      if (push) m_fifo.push_back(event_in);
      if (spike_in && !push) begin
        m_ovf = 1;
        m_drops = clear_overflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clear_overflow) begin
        m_ovf = 0; m_drops = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    byte_ready = 1'b1; spike_in = 1'b0; clear_overflow = 1'b0;
    for (int c = 0; c < 300 && (m_out.size() > 0 || m_fifo.size() > 0); c++) tick();
    tick();
  endtask

  task automatic fill_fifo(input int n);
    byte_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      spike_in = 1'b1; event_in = 24'($urandom); tick();
    end
    spike_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_tests += 5;
    if (byte_out !== 8'h00)   begin n_fail++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
    if (byte_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (drop_count !== 8'd0)  begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    if (fifo_level !== 5'd0)  begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_single_event();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'h05; exp[2] = 8'h0A;
    byte_ready = 1'b1; spike_in = 1'b1; event_in = {16'h0005, 8'd10}; tick();
    spike_in = 1'b0;
    n_tests += 2;
    if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", byte_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (byte_valid !== 1'b1 || byte_out !== exp[i]) begin
        n_fail++; $display("FAIL single_byte%0d: got v=%b %h want v=1 %h", i, byte_valid, byte_out, exp[i]);
      end
      tick();
    end
    n_tests++;
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b want 0", byte_valid); end
  endtask

  task automatic test_ready_toggle();
    logic [7:0] exp [3];
    logic [7:0] got[$];
    bit held = 0;
    logic [7:0] held_val = '0;
    exp[0] = 8'h00; exp[1] = 8'h05; exp[2] = 8'h0A;
    byte_ready = 1'b0; spike_in = 1'b1; event_in = {16'h0005, 8'd10}; tick();
    spike_in = 1'b0;
    for (int c = 0; c < 14; c++) begin
      byte_ready = c[0];
      if (held) begin
        n_tests++;
        if (byte_valid !== 1'b1 || byte_out !== held_val) begin
          n_fail++; $display("FAIL toggle_hold: got v=%b %h want v=1 %h", byte_valid, byte_out, held_val);
        end
      end
      held = 0;
      if (byte_valid === 1'b1) begin
        if (byte_ready) got.push_back(byte_out);
        else begin held = 1; held_val = byte_out; end
      end
      tick();
    end
    n_tests++;
    if (got.size() != 3) begin n_fail++; $display("FAIL toggle_count: got %0d want 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL toggle_byte%0d: got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_burst_overflow();
    logic [23:0] sent[$];
    int k = 0;
    byte_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spike_in = 1'b1; event_in = 24'($urandom); sent.push_back(event_in); tick();
    end
    spike_in = 1'b0;
    n_tests += 3;
    if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL burst_level: got %0d want 16", fifo_level); end
    if (drop_count !== 8'd3)  begin n_fail++; $display("FAIL burst_drop: got %0d want 3", drop_count); end
    if (overflow !== 1'b1)    begin n_fail++; $display("FAIL burst_ovf: got %b want 1", overflow); end
    byte_ready = 1'b1;
    for (int c = 0; c < 200 && k < 17*EB; c++) begin
      if (byte_valid === 1'b1) begin
        n_tests++;
        if (byte_out !== sent[k/EB][23-8*(k%EB) -: 8]) begin
          n_fail++; $display("FAIL burst_drain_byte%0d: got %h want %h", k, byte_out, sent[k/EB][23-8*(k%EB) -: 8]);
        end
        k++;
      end
      tick();
    end
    n_tests += 2;
    if (k != 17*EB) begin n_fail++; $display("FAIL burst_drain_timeout: got %0d bytes want %0d", k, 17*EB); end
    if (byte_valid !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL burst_drained: got v=%b lvl=%0d want v=0 lvl=0", byte_valid, fifo_level);
    end
  endtask

  task automatic test_full_pop_push();
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    fill_fifo(17);
    byte_ready = 1'b1; tick(); tick();
    spike_in = 1'b1; event_in = 24'($urandom); tick();
    spike_in = 1'b0; byte_ready = 1'b0;
    n_tests += 3;
    if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL fullpop_level: got %0d want 16", fifo_level); end
    if (drop_count !== 8'd0)  begin n_fail++; $display("FAIL fullpop_drop: got %0d want 0", drop_count); end
    if (overflow !== 1'b0)    begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    drain();
    n_tests++;
    if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL fullpop_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_clear_overflow();
    fill_fifo(17);
    for (int i = 1; i <= 2; i++) begin
      spike_in = 1'b1; tick();
      n_tests++;
      if (drop_count !== 8'(i)) begin n_fail++; $display("FAIL clr_pre_drop%0d: got %0d want %0d", i, drop_count, i); end
    end
    clear_overflow = 1'b1; tick();
    spike_in = 1'b0;
    n_tests += 2;
    if (overflow !== 1'b1)   begin n_fail++; $display("FAIL clr_same_ovf: got %b want 1", overflow); end
    if (drop_count !== 8'd1) begin n_fail++; $display("FAIL clr_same_drop: got %0d want 1", drop_count); end
    tick();
    clear_overflow = 1'b0;
    n_tests += 2;
    if (overflow !== 1'b0)   begin n_fail++; $display("FAIL clr_alone_ovf: got %b want 0", overflow); end
    if (drop_count !== 8'd0) begin n_fail++; $display("FAIL clr_alone_drop: got %0d want 0", drop_count); end
    drain();
  endtask

  task automatic test_reset_mid_event();
    logic [23:0] c_ev;
    byte_ready = 1'b1;
    spike_in = 1'b1; event_in = 24'($urandom); tick();
    event_in = 24'($urandom); tick();
    spike_in = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests += 2;
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", byte_valid); end
    if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
    c_ev = 24'($urandom);
    spike_in = 1'b1; event_in = c_ev; tick();
    spike_in = 1'b0; tick();
    for (int i = 0; i < EB; i++) begin
      n_tests++;
      if (byte_valid !== 1'b1 || byte_out !== c_ev[23-8*i -: 8]) begin
        n_fail++; $display("FAIL rstmid_byte%0d: got v=%b %h want v=1 %h", i, byte_valid, byte_out, c_ev[23-8*i -: 8]);
      end
      tick();
    end
    n_tests++;
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_end_valid: got %b want 0", byte_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      spike_in       = ($urandom_range(0, 99) < ((c % 300) < 150 ? 70 : 25));
      event_in       = 24'($urandom);
      byte_ready     = ($urandom_range(0, 99) < 60);
      clear_overflow = ($urandom_range(0, 31) == 0);
      n_tests += 4;
      if (byte_valid !== (m_out.size() > 0)) begin
        n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, byte_valid, m_out.size() > 0);
      end else if (byte_valid === 1'b1 && byte_out !== m_out[0]) begin
        n_fail++; $display("FAIL rand_byte c%0d: got %h want %h", c, byte_out, m_out[0]);
      end
      if (fifo_level !== 5'(m_fifo.size())) begin
        n_fail++; $display("FAIL rand_level c%0d: got %0d want %0d", c, fifo_level, m_fifo.size());
      end
      if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c%0d: got %b want %b", c, overflow, m_ovf); end
      if (drop_count !== 8'(m_drops)) begin
        n_fail++; $display("FAIL rand_drop c%0d: got %0d want %0d", c, drop_count, m_drops);
      end
      tick();
    end
    drain();
    n_tests++;
    if (byte_valid !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL rand_drained: got v=%b lvl=%0d want v=0 lvl=0", byte_valid, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_ready_toggle();
    test_burst_overflow();
    test_full_pop_push();
    test_clear_overflow();
    test_reset_mid_event();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
